// File: rtl/cong_serial.sv
// rtl/cong_serial.sv - bit-serial WIDTH-bit adder, one full-adder slice and a carry flop
// Operands load on start; sum, carry-out and signed overflow arrive with a one-cycle done.
module cong_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic             sbit_d;
   logic             carry_d;
   logic [WIDTH-1:0] sum_d;
   logic             last_bit;

   // Single full-adder slice on the current LSB pair
   assign sbit_d   = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   assign sum_d    = {sbit_d, sum_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= {1'b0, a_q[WIDTH-1:1]};
               b_q     <= {1'b0, b_q[WIDTH-1:1]};
               carry_q <= carry_d;
               sum_q   <= sum_d;
               cnt_q   <= cnt_q + CW'(1);
               // carry_q here is the carry into the MSB
               if (last_bit) begin
                  s_q     <= sum_d;
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_cong_serial.sv
// tb/tb_cong_serial.sv - scoreboard bench for cong_serial at WIDTH=8
// Stimulus pushes expected {S,cout,ovf}; a negedge monitor pops on every done.
module tb_cong_serial;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       cin = 1'b0;
   logic       busy, done, cout, ovf;
   logic [7:0] S;

   int n_chk = 0;
   int n_fail = 0;
   int n_acc = 0;
   int n_done = 0;
   logic [9:0] exp_q[$];
   logic prev_done = 1'b0;

   cong_serial #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .cin(cin),
      .busy(busy), .done(done), .S(S), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] t;
      logic       v;
      t = {1'b0, a} + {1'b0, b} + {8'd0, c};
      v = (a[7] == b[7]) && (t[7] != a[7]);
      return {t[7:0], t[8], v};
   endfunction

   // Monitor: every done must match the oldest outstanding request
   always @(negedge clk) begin
      if (rst_n && done) begin
         n_done++;
         if (prev_done) chk("done_single_cycle", 32'(prev_done), 32'(0));
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(1), 32'(0));
         end else begin
            chk("result_S_cout_ovf", 32'({S, cout, ovf}), 32'(exp_q.pop_front()));
         end
      end
      prev_done = done;
   end

   // Wait for an accepting cycle, issue one request, drop start after the edge
   task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c);
      int t;
      t = 0;
      while (busy && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("wait_idle_timeout", 32'(busy), 32'(0));
      start = 1'b1; A = a; B = b; cin = c;
      exp_q.push_back(model(a, b, c));
      n_acc++;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_low);
      lat = 0;
      busy_low = 0;
      while (!done && lat < 30) begin
         if (!busy) busy_low++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic add_lat(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c);
      int lat, bl;
      do_add(a, b, c);
      wait_done(lat, bl);
      chk({nm, "_latency"}, 32'(lat), 32'(8));
      chk({nm, "_busy_held"}, 32'(bl), 32'(0));
   endtask

   initial begin
      int lat, bl;
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_S", 32'(S), 32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      add_lat("add_05_03", 8'h05, 8'h03, 1'b0);
      @(negedge clk);
      chk("done_falls", 32'(done), 32'(0));
      chk("S_holds", 32'(S), 32'h08);

      add_lat("add_ff_01", 8'hFF, 8'h01, 1'b0);
      add_lat("add_7f_00_c", 8'h7F, 8'h00, 1'b1);
      add_lat("add_80_80", 8'h80, 8'h80, 1'b0);
      @(negedge clk);

      // Start during RUN must be ignored
      do_add(8'h10, 8'h20, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; A = 8'hAA; B = 8'h55; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bl);
      chk("ignore_latency", 32'(lat + 3), 32'(8));
      chk("ignore_busy_held", 32'(bl), 32'(0));
      chk("ignore_S", 32'(S), 32'h30);
      @(negedge clk);
      @(negedge clk);
      chk("ignore_no_second", 32'({busy, done}), 32'(0));

      // Back-to-back: start held, new operands presented in the DONE cycle
      start = 1'b1; A = 8'h01; B = 8'h01; cin = 1'b0;
      exp_q.push_back(model(8'h01, 8'h01, 1'b0));
      n_acc++;
      @(negedge clk);
      wait_done(lat, bl);
      chk("b2b_first_latency", 32'(lat), 32'(8));
      A = 8'h0F; B = 8'h01;
      exp_q.push_back(model(8'h0F, 8'h01, 1'b0));
      n_acc++;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy_rises", 32'({busy, done}), 32'b10);
      lat = 1;
      bl = 0;
      while (!done && lat < 30) begin
         if (S !== 8'h02) bl++;
         @(negedge clk);
         lat++;
      end
      chk("b2b_period", 32'(lat), 32'(9));
      chk("b2b_S_held", 32'(bl), 32'(0));
      @(negedge clk);

      // Async reset mid-RUN aborts the addition
      do_add(8'h12, 8'h34, 1'b0);
      void'(exp_q.pop_back());
      n_acc--;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outputs", 32'({busy, done, S, cout, ovf}), 32'(0));
      @(negedge clk);
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      add_lat("post_rst_33_11", 8'h33, 8'h11, 1'b0);
      chk("post_rst_S", 32'(S), 32'h44);

      for (int i = 0; i < 1000; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) @(negedge clk);
         do_add(8'($urandom), 8'($urandom), 1'($urandom));
      end
      for (int w = 0; w < 30 && exp_q.size() != 0; w++) @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      chk("done_per_start", 32'(n_done), 32'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
